mod8191_mul_sched: RTL and testbench
====================================

Name: mod8191_mul_sched

Overview:
- Shares one pipelined mod-8191 multiplier (13b x 13b -> 26b product -> reduce mod 2^13-1) among NUM_REQ requesters in the masked-arithmetic datapath.
- Round-robin arbitration with a valid/ready request per requester.
- One tagged response stream with backpressure.
- Each masked share-arithmetic unit uses this block instead of owning a multiplier.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- ID_W, 2, response tag width; must be >= clog2(NUM_REQ).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  13*NUM_REQ  operand A; slice i = [13i+12:13i]
- req_b  in  13*NUM_REQ  operand B, same packing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_id  out  ID_W  index of the requester that owns rsp_data
- rsp_data  out  13  (a*b) mod 8191, canonical range 0..8190
- busy  out  1  any pipeline stage valid

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, rr_ptr=0, all data/id registers 0. Outputs during reset: rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0.
- Pipeline enable: en = !(s2_valid && !rsp_ready). The whole pipeline advances only when en=1; it stalls as a unit.
- Arbitration: scan requesters starting at rr_ptr, wrapping around.
  - gnt = first i with req_valid[i].
  - req_ready[i] = (i==gnt) && en && req_valid[i].
  - req_ready is combinational from req_valid, rr_ptr, s2_valid and rsp_ready.
- Accept: a handshake occurs when req_valid[i] && req_ready[i]. On the accepting edge:
  - s1_prod <= a*b (26b, unsigned).
  - s1_id <= i.
  - rr_ptr <= (i+1) mod NUM_REQ.
- When en=1 and no handshake occurs: s1_valid <= 0 (a bubble enters), and rr_ptr is unchanged.
- Stage 2, when en=1: s2_valid <= s1_valid, s2_id <= s1_id, s2_data <= reduce(s1_prod).
- reduce(p):
  - x = p[25:13] + p[12:0] (14b).
  - y = x[13] + x[12:0].
  - Result = 0 if y==8191, else y[12:0].
- rsp_valid=s2_valid, rsp_id=s2_id, rsp_data=s2_data.
- Latency: a request accepted at edge N gives rsp_valid=1 after edge N+1, provided no stall occurs.
- Throughput: 1 result/cycle. Bubbles are not collapsed during a stall.
- Stall: while rsp_valid && !rsp_ready, rsp_id/rsp_data hold stable, s1 holds, and every req_ready=0.
- Operand 8191 (≡0) is legal and yields 0. No input range check.
- Simultaneous events:
  - rsp handshake and new accept in the same cycle are both legal.
  - Multiple req_valid: exactly one grant per cycle.
- No internal ordering queue; responses leave in acceptance order.
- busy = s1_valid || s2_valid.
- Reset mid-operation discards in-flight results with no response.
- Requester protocol: req_a/req_b/req_valid must hold stable until accepted. The block does not check this.

Decomposition:
- Shared package:
  - MOD_W=13, MOD_P=13'h1FFF, PROD_W=26.
  - Helper function or localparam for the ID width check.
- Sub-module: reuse the existing combinational 26b->13b mod-8191 reduction module between s1_prod and s2_data. No other sub-modules.
- Multiplier is an inline combinational multiply into s1.

Test Plan:
- Single req0, a=1234, b=1, rsp_ready=1 -> req_ready[0]=1 in the accept cycle; rsp_valid one cycle after the accepting edge; rsp_data=1234, rsp_id=0.
- Arithmetic corners on req1:
  - 8190*8190 -> 1.
  - 4096*2 -> 1.
  - 8191*5 -> 0.
  - 0*8190 -> 0.
  - 8191*8191 -> 0.
  - 91*90 -> 8190.
- Both requesters valid for 6 cycles, rsp_ready=1 -> grants alternate 0,1,0,1,0,1; rsp_id sequence matches, one result per cycle.
- rsp_ready=0 for 3 cycles with 2 results in flight -> rsp_data/rsp_id constant, all req_ready=0. After release, both results drain in order, with no loss or duplication.
- Assert rst for 1 cycle while s1 and s2 are valid -> rsp_valid and busy drop immediately (async). No stale response after deassert; the next accept goes to req0 (rr_ptr=0).
- Random soak, NUM_REQ=4, random valid/ready, 10k ops -> scoreboard matches (a*b)%8191 per id. Each requester starves at most 3 grants.

Source files
------------

// File: rtl/mod8191_mul_sched_pkg.sv
// Shared constants for the mod-8191 multiplier scheduler and its reduction stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mod8191_mul_sched_pkg;

  localparam int               MOD_W  = 13;
  localparam logic [MOD_W-1:0] MOD_P  = 13'h1FFF;
  localparam int               PROD_W = 26;

  // Legal configurations: 2..4 requesters, tag wide enough to name every requester.
  function automatic bit id_w_ok(input int num_req, input int id_w);
    return (num_req >= 2) && (num_req <= 4) && (id_w >= $clog2(num_req));
  endfunction

endpackage

// File: rtl/mod8191_mul_sched_reduce.sv
// Combinational reduction of a 26-bit product modulo 2^13-1 to canonical range 0..8190.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: i_prod - 26-bit unsigned product; o_res - canonical residue.
module mod8191_mul_sched_reduce
  import mod8191_mul_sched_pkg::*;
(
  input  logic [PROD_W-1:0] i_prod,
  output logic [MOD_W-1:0]  o_res
);

  logic [MOD_W:0] w_x;
  logic [MOD_W:0] w_y;

  // 2^13 == 1 (mod 8191), so the high half folds onto the low half.
  // Two folds bring the value to 0..8191; 8191 itself is the non-canonical zero.
  always_comb begin
    w_x   = {1'b0, i_prod[PROD_W-1:MOD_W]} + {1'b0, i_prod[MOD_W-1:0]};
    w_y   = {{MOD_W{1'b0}}, w_x[MOD_W]} + {1'b0, w_x[MOD_W-1:0]};
    o_res = (w_y == {1'b0, MOD_P}) ? '0 : w_y[MOD_W-1:0];
  end

endmodule

// File: rtl/mod8191_mul_sched.sv
// Round-robin scheduler sharing one 2-stage mod-8191 multiplier among NUM_REQ requesters.
// Latency: accept at edge N -> rsp_valid after edge N+1; 1 result per cycle.
// Backpressure: rsp_valid && !rsp_ready stalls the whole pipeline and drops all req_ready.
// Ports: clk/rst (async active-high); req_valid/req_ready/req_a/req_b per requester,
//        13-bit operand slice i at [13i+12:13i]; rsp_valid/rsp_ready/rsp_id/rsp_data
//        tagged result stream; busy = any stage valid.
module mod8191_mul_sched
  import mod8191_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 2
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [MOD_W*NUM_REQ-1:0] req_a,
  input  logic [MOD_W*NUM_REQ-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MOD_W-1:0]         rsp_data,
  output logic                     busy
);

  if (!id_w_ok(NUM_REQ, ID_W)) begin : g_bad_params
    $error("mod8191_mul_sched: illegal NUM_REQ/ID_W combination");
  end

  logic                 r_s1_vld;
  logic [PROD_W-1:0]    r_s1_prod;
  logic [ID_W-1:0]      r_s1_id;
  logic                 r_s2_vld;
  logic [ID_W-1:0]      r_s2_id;
  logic [MOD_W-1:0]     r_s2_dat;
  logic [ID_W-1:0]      r_rr_ptr;

  logic                 w_en;
  logic                 w_any;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [ID_W:0]        w_pos;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_gnt_idx;
  logic [ID_W-1:0]      w_nxt_ptr;
  logic [NUM_REQ-1:0]   w_rdy;
  logic                 w_acc;
  logic [MOD_W-1:0]     w_a;
  logic [MOD_W-1:0]     w_b;
  logic [PROD_W-1:0]    w_prod;
  logic [MOD_W-1:0]     w_red;

  assign w_en  = !(r_s2_vld && !rsp_ready);
  assign w_any = |req_valid;

  // Rotating the doubled valid vector by rr_ptr puts the scan start at bit 0;
  // the lowest set bit is the offset of the winner from rr_ptr. When any valid
  // is set, that bit always lies in the low NUM_REQ positions.
  assign w_rot = {req_valid, req_valid} >> r_rr_ptr;

  always_comb begin
    w_pos = '0;
    for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
      if (w_rot[j]) w_pos = (ID_W+1)'(j);
    end
    w_sum = {1'b0, r_rr_ptr} + w_pos;
    if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
    w_gnt_idx = w_sum[ID_W-1:0];
    w_nxt_ptr = (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  end

  // Grant gating and operand mux; req_ready is forced low while reset is held.
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_a = req_a[i*MOD_W +: MOD_W];
        w_b = req_b[i*MOD_W +: MOD_W];
      end
      w_rdy[i] = !rst && w_en && w_any && (w_gnt_idx == ID_W'(i));
    end
  end

  assign req_ready = w_rdy;
  assign w_acc     = |w_rdy;
  assign w_prod    = {{MOD_W{1'b0}}, w_a} * {{MOD_W{1'b0}}, w_b};

  mod8191_mul_sched_reduce u_reduce (
    .i_prod (r_s1_prod),
    .o_res  (w_red)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_prod <= '0;
      r_s1_id   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_id   <= '0;
      r_s2_dat  <= '0;
      r_rr_ptr  <= '0;
    end else if (w_en) begin
      // No handshake inserts a bubble; stalls freeze both stages together.
      r_s1_vld <= w_acc;
      if (w_acc) begin
        r_s1_prod <= w_prod;
        r_s1_id   <= w_gnt_idx;
        r_rr_ptr  <= w_nxt_ptr;
      end
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      r_s2_dat <= w_red;
    end
  end

  assign rsp_valid = r_s2_vld;
  assign rsp_id    = r_s2_id;
  assign rsp_data  = r_s2_dat;
  assign busy      = r_s1_vld || r_s2_vld;

endmodule

// File: tb/tb_mod8191_mul_sched.sv
// Self-checking bench for mod8191_mul_sched (NUM_REQ=4) with a response scoreboard.
// Latency: n/a (testbench).
// Backpressure: drives random rsp_ready in the soak phase.
module tb_mod8191_mul_sched;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_ready;
  logic [13*NR-1:0] req_a;
  logic [13*NR-1:0] req_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_id;
  logic [12:0]   rsp_data;
  logic          busy;

  always #5 clk = ~clk;

  mod8191_mul_sched #(.NUM_REQ(NR), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct { int id; int dat; } exp_t;
  typedef struct { int rq; int a; int b; int exp; } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_acc = 0;
  int   wait_cnt[NR];

  function automatic int model(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p % 8191);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_valid[i]        = 1'b1;
    req_a[i*13 +: 13]   = 13'(a);
    req_b[i*13 +: 13]   = 13'(b);
  endtask

  // Sample handshakes mid-cycle, update scoreboard, advance one edge, clear accepted valids.
  task automatic tick();
    logic [NR-1:0] hs;
    logic          rhs;
    exp_t          e;
    #1;
    hs  = req_valid & req_ready;
    rhs = rsp_valid && rsp_ready;
    chk("req_ready_onehot", longint'($countones(req_ready) <= 1), 1);
    if (rhs) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.dat);
      end
    end
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        e.id  = i;
        e.dat = model(int'(req_a[i*13 +: 13]), int'(req_b[i*13 +: 13]));
        sb.push_back(e);
        n_acc++;
        chk("starve", longint'(wait_cnt[i] <= 3), 1);
        wait_cnt[i] = 0;
        for (int j = 0; j < NR; j++) begin
          if (j != i && req_valid[j]) wait_cnt[j]++;
        end
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~hs;
  endtask

  task automatic drain();
    for (int c = 0; c < 50; c++) begin
      if (sb.size() == 0 && !busy) break;
      tick();
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int   e0;
    int   start_acc;
    int   cyc;

    tbl[0] = '{0, 1234, 1,    1234};
    tbl[1] = '{1, 8190, 8190, 1};
    tbl[2] = '{1, 4096, 2,    1};
    tbl[3] = '{1, 8191, 5,    0};
    tbl[4] = '{1, 0,    8190, 0};
    tbl[5] = '{1, 8191, 8191, 0};
    tbl[6] = '{1, 91,   90,   8190};

    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    req_valid = '1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    req_valid = '0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    // Single-request latency and arithmetic corners.
    for (int k = 0; k < 7; k++) begin
      set_req(tbl[k].rq, tbl[k].a, tbl[k].b);
      #1;
      chk("tbl_grant", req_ready, 1 << tbl[k].rq);
      tick();
      req_valid = '0;
      chk("tbl_lat_s1", rsp_valid, 0);
      chk("tbl_busy_s1", busy, 1);
      tick();
      chk("tbl_rsp_valid", rsp_valid, 1);
      chk("tbl_rsp_data", rsp_data, tbl[k].exp);
      chk("tbl_rsp_id", rsp_id, tbl[k].rq);
      tick();
      chk("tbl_idle", busy, 0);
    end

    // Two requesters continuously valid: grants alternate, full throughput.
    set_req(0, $urandom_range(0, 8191), $urandom_range(0, 8191));
    set_req(1, $urandom_range(0, 8191), $urandom_range(0, 8191));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_grant", req_ready, (k % 2 == 1) ? 2 : 1);
      if (k >= 2) chk("alt_tput", rsp_valid, 1);
      tick();
      if (k < 5) set_req(k % 2, $urandom_range(0, 8191), $urandom_range(0, 8191));
    end
    req_valid = '0;
    drain();

    // Stall with two results in flight.
    rsp_ready = 1'b0;
    set_req(0, 777, 555);
    e0 = model(777, 555);
    tick();
    set_req(1, 4321, 1111);
    tick();
    set_req(2, 100, 200);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_req_ready", req_ready, 0);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_id", rsp_id, 0);
      chk("stall_rsp_data", rsp_data, e0);
      tick();
    end
    rsp_ready = 1'b1;
    drain();

    // Asynchronous reset with both stages full; rr_ptr left at 1 beforehand.
    set_req(1, 3000, 3);
    tick();
    set_req(0, 17, 19);
    tick();
    req_valid = 4'b0011;
    rst       = 1'b1;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_req_ready", req_ready, 0);
    sb.delete();
    for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    tick();
    chk("arst_no_stale0", rsp_valid, 0);
    tick();
    chk("arst_no_stale1", rsp_valid, 0);
    set_req(0, 11, 13);
    set_req(1, 12, 14);
    #1;
    chk("arst_rr_ptr0", req_ready, 1);
    tick();
    drain();

    // Random soak.
    start_acc = n_acc;
    cyc       = 0;
    while ((n_acc - start_acc) < 10000 && cyc < 40000) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, $urandom_range(0, 8191), $urandom_range(0, 8191));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("soak_ops_done", longint'((n_acc - start_acc) >= 10000), 1);
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
